// File: rtl/usb_pkg.sv
// Shared sizing for the USB data buffer, also consumed by the receiver and
// transmitter blocks that watch buffer_occupancy.
package usb_pkg;
  localparam int BUF_DEPTH  = 64;
  localparam int BUF_DATA_W = 8;
  localparam int BUF_OCC_W  = 7;
  localparam int BUF_IDX_W  = BUF_OCC_W - 1;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer control for the USB byte FIFO: full/empty, registered
// occupancy and the one-cycle buffer_err pulse.
module fifo_ptr_ctrl
  import usb_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int OCC_W = BUF_OCC_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     empty,
  output logic                     full,
  output logic [OCC_W-1:0]         occupancy,
  output logic                     buffer_err
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [OCC_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             err_nxt;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                  (wr_ptr[OCC_W-1] != rd_ptr[OCC_W-1]);

  // A simultaneous pop frees the slot the push lands in, so push+pop is legal when full;
  // pop on empty alongside a push is silently ignored.
  always_comb begin
    wr_nxt  = wr_ptr;
    rd_nxt  = rd_ptr;
    wr_en   = 1'b0;
    err_nxt = 1'b0;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (push && (!full || pop)) begin
        wr_en  = 1'b1;
        wr_nxt = wr_ptr + OCC_W'(1);
      end
      if (pop && !empty)
        rd_nxt = rd_ptr + OCC_W'(1);
      err_nxt = (push && !pop && full) || (pop && !push && empty);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      buffer_err <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      occupancy  <= wr_nxt - rd_nxt;
      buffer_err <= err_nxt;
    end
  end
endmodule

// File: rtl/usb_data_buffer.sv
// Byte FIFO shared by the USB RX path, the TX path and the host side.
// Show-ahead head byte, zeroed while empty.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int DATA_W = BUF_DATA_W,
  parameter int OCC_W  = BUF_OCC_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              store_rx_packet_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              get_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] tx_packet_data,
  input  logic              flush,
  input  logic              clear,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              buffer_err
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              push, pop, wr_en, empty, full;
  logic [DATA_W-1:0] wdata, head;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Receiver wins when both sides push in the same cycle.
  assign push  = store_rx_packet_data | store_tx_data;
  assign wdata = store_rx_packet_data ? rx_packet_data : tx_data;
  assign pop   = get_rx_data | get_tx_packet_data;

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .OCC_W(OCC_W)) u_ptr (
    .clk        (clk),
    .n_rst      (n_rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush | clear),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .empty      (empty),
    .full       (full),
    .occupancy  (buffer_occupancy),
    .buffer_err (buffer_err)
  );

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wdata;
  end

  assign head           = empty ? '0 : mem[rd_idx];
  assign rx_data        = head;
  assign tx_packet_data = head;
endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_usb_data_buffer;
  logic       clk = 1'b0;
  logic       n_rst;
  logic       srx, stx, grx, gtx, fl, cl;
  logic [7:0] rxd, txd;
  logic [7:0] rx_data, tx_packet_data;
  logic [6:0] occ;
  logic       err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .store_rx_packet_data (srx),
    .rx_packet_data       (rxd),
    .get_rx_data          (grx),
    .rx_data              (rx_data),
    .store_tx_data        (stx),
    .tx_data              (txd),
    .get_tx_packet_data   (gtx),
    .tx_packet_data       (tx_packet_data),
    .flush                (fl),
    .clear                (cl),
    .buffer_occupancy     (occ),
    .buffer_err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] h;
    h = (q.size() > 0) ? q[0] : 8'h00;
    chk({tag, ".occ"}, 32'(occ), 32'(q.size()));
    chk({tag, ".rx_data"}, 32'(rx_data), 32'(h));
    chk({tag, ".tx_data"}, 32'(tx_packet_data), 32'(h));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  // Drive one cycle from a negedge, update the model, then check at the next negedge.
  task automatic step(input string tag, input logic a_srx, input logic [7:0] a_rxd,
                      input logic a_stx, input logic [7:0] a_txd,
                      input logic a_grx, input logic a_gtx,
                      input logic a_fl, input logic a_cl);
    logic       p, o;
    logic [7:0] d;
    srx = a_srx; rxd = a_rxd; stx = a_stx; txd = a_txd;
    grx = a_grx; gtx = a_gtx; fl = a_fl; cl = a_cl;
    p = a_srx | a_stx;
    o = a_grx | a_gtx;
    d = a_srx ? a_rxd : a_txd;
    exp_err = 1'b0;
    if (a_fl || a_cl) q.delete();
    else if (p && o) begin
      if (q.size() > 0) void'(q.pop_front());
      q.push_back(d);
    end else if (p) begin
      if (q.size() == 64) exp_err = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) exp_err = 1'b1;
      else void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    srx = 0; stx = 0; grx = 0; gtx = 0; fl = 0; cl = 0; rxd = 0; txd = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_state("reset");

    // 1: single byte round trip
    step("t1.push", 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);
    chk("t1.head", 32'(rx_data), 32'h A5);
    step("t1.pop", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 64; i++)
      if (i % 2 == 0) step("t2.fill", 1, 8'(i), 0, 8'h00, 0, 0, 0, 0);
      else            step("t2.fill", 0, 8'h00, 1, 8'(i), 0, 0, 0, 0);
    chk("t2.full_occ", 32'(occ), 32'd64);
    step("t2.overflow", 1, 8'hEE, 0, 8'h00, 0, 0, 0, 0);
    chk("t2.err_pulse", 32'(err), 32'd1);
    idle("t2.err_clear");
    for (int i = 0; i < 64; i++) begin
      chk("t2.order", 32'(rx_data), 32'(i));
      step("t2.drain", 0, 8'h00, 0, 8'h00, i % 2 == 0, i % 3 == 0 || i % 2 == 1, 0, 0);
    end

    // 3: partial pop/push cycles force index wrap
    for (int i = 0; i < 64; i++) step("t3.fill", 0, 8'h00, 1, 8'(8'h40 + i), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step("t3.pop", 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) step("t3.push", 1, 8'(8'hC0 + i), 0, 8'h00, 0, 0, 0, 0);
    chk("t3.occ", 32'(occ), 32'd64);
    for (int i = 0; i < 64; i++) step("t3.drain", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);

    // 4: push+pop when full and when empty
    for (int i = 0; i < 64; i++) step("t4.fill", 1, 8'(i), 0, 8'h00, 0, 0, 0, 0);
    step("t4.full_pp", 0, 8'h00, 1, 8'h77, 1, 0, 0, 0);
    chk("t4.full_pp_noerr", 32'(err), 32'd0);
    for (int i = 0; i < 63; i++) step("t4.drain", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    chk("t4.last", 32'(tx_packet_data), 32'h77);
    step("t4.drain_last", 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    step("t4.empty_pp", 1, 8'h3C, 0, 8'h00, 0, 1, 0, 0);
    chk("t4.empty_pp_occ", 32'(occ), 32'd1);
    step("t4.pop", 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);

    // 5: flush and clear discard a concurrent push
    for (int i = 0; i < 10; i++) step("t5.fill", 1, 8'(i + 1), 0, 8'h00, 0, 0, 0, 0);
    step("t5.flush", 1, 8'h99, 0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step("t5.fill2", 0, 8'h00, 1, 8'(i + 1), 0, 0, 0, 0);
    step("t5.clear", 0, 8'h00, 1, 8'h99, 1, 0, 0, 1);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step("t6.fill", 1, 8'(i + 1), 0, 8'h00, 0, 0, 0, 0);
    chk("t6.occ5", 32'(occ), 32'd5);
    srx = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("t6.rst_occ", 32'(occ), 32'd0);
    chk("t6.rst_err", 32'(err), 32'd0);
    chk("t6.rst_head", 32'(rx_data), 32'd0);
    q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    idle("t6.release");
    step("t6.pop_empty", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    chk("t6.err_once", 32'(err), 32'd1);
    idle("t6.err_gone");

    // 7: random traffic
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 300) % 3;  // shift push/pop balance so both full and empty are visited
      step("rand",
           $urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 25 : 45)), 8'($urandom),
           $urandom_range(99) < (bias == 0 ? 40 : 15), 8'($urandom),
           $urandom_range(99) < (bias == 1 ? 60 : 25),
           $urandom_range(99) < (bias == 1 ? 40 : 20),
           $urandom_range(999) < 5, $urandom_range(999) < 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
